// File: rtl/blit_ramarbn_pkg.sv
// Shared definitions for the blit RAM arbiter.
//   state_t    : arbiter FSM encoding (idle / access in flight)
//   RR_FIXED   : RR parameter value selecting fixed priority, port 0 highest
//   RR_ROUND   : RR parameter value selecting round-robin
//   idx_width  : width of a port index for a given port count (at least 1 bit)
package blit_ramarbn_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blit_rrpick.sv
// Combinational rotating priority picker.
// Starting at index 'start' and walking upward (wrapping NPORTS-1 -> 0),
// the first set bit of 'mask' wins.  With start tied to zero this is a
// plain lowest-index-first priority encoder.
//   mask  : candidate ports
//   start : first index to consider, must be < NPORTS
//   grant : one-hot winner (zero when mask is empty)
//   index : binary winner index (zero when mask is empty)
//   any   : mask had at least one bit set
module blit_rrpick
  import blit_ramarbn_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int IW     = idx_width(NPORTS)
) (
  input  logic [NPORTS-1:0] mask,
  input  logic [IW-1:0]     start,
  output logic [NPORTS-1:0] grant,
  output logic [IW-1:0]     index,
  output logic              any
);

  // One spare bit so start + k can exceed NPORTS-1 before the wrap.
  logic [IW:0] pos;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      pos = (IW + 1)'(start) + (IW + 1)'(k);
      if (pos >= (IW + 1)'(NPORTS)) begin
        pos = pos - (IW + 1)'(NPORTS);
      end
      if (!any && mask[pos[IW-1:0]]) begin
        any                = 1'b1;
        grant[pos[IW-1:0]] = 1'b1;
        index              = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/blit_ramarbn.sv
// N-port RAM arbiter: serialises req/ack masters onto the single blit RAM port.
// One access is outstanding at a time.  In IDLE the winner among the eligible
// requesters (req & ~ack) is registered onto the ram_* bus; in BUSY the bus is
// held until ram_ack, after which the winner gets a one-cycle ack with the read
// data.  Urgent requesters pre-empt non-urgent ones at arbitration time.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req, urgent, we           per-port request / urgency / write enable
//   addr, wdata, wstrb        per-port access fields, port p at [p*W +: W]
//   ack                       one-cycle completion pulse to the winner
//   rdata                     RAM data captured at completion
//   ram_req                   RAM request, held until ram_ack
//   ram_addr/wdata/wstrb/we   registered copy of the winning access
//   ram_ack, ram_rdata        RAM completion pulse and read data
module blit_ramarbn
  import blit_ramarbn_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int AW     = 18,
  parameter int DW     = 16,
  parameter int RR     = RR_FIXED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        urgent,
  input  logic [NPORTS*AW-1:0]     addr,
  input  logic [NPORTS*DW-1:0]     wdata,
  input  logic [NPORTS*(DW/8)-1:0] wstrb,
  input  logic [NPORTS-1:0]        we,
  output logic [NPORTS-1:0]        ack,
  output logic [DW-1:0]            rdata,
  output logic                     ram_req,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_wdata,
  output logic [DW/8-1:0]          ram_wstrb,
  output logic                     ram_we,
  input  logic                     ram_ack,
  input  logic [DW-1:0]            ram_rdata
);

  localparam int SW = DW / 8;
  localparam int IW = idx_width(NPORTS);

  state_t state_reg, state_next;

  logic [IW-1:0]     g_reg;
  logic [IW-1:0]     rr_ptr_reg;
  logic [IW-1:0]     rr_next;
  logic [IW-1:0]     pick_start;
  logic [NPORTS-1:0] g_onehot;

  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] urgent_elig;
  logic [NPORTS-1:0] urg_grant, all_grant, win_grant;
  logic [IW-1:0]     urg_index, all_index, win_index;
  logic              urg_any, all_any;

  logic load_win;
  logic finish;

  logic [AW-1:0]     addr_m  [NPORTS];
  logic [DW-1:0]     wdata_m [NPORTS];
  logic [SW-1:0]     wstrb_m [NPORTS];
  logic [NPORTS-1:0] we_m;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;
  logic [SW-1:0]     win_wstrb;
  logic              win_we;

  // A port that is being acked this cycle still holds req; masking it stops
  // the same access from being granted twice.
  assign eligible    = req & ~ack;
  assign urgent_elig = eligible & urgent;
  assign pick_start  = (RR == RR_ROUND) ? rr_ptr_reg : '0;

  // Two pickers share the start pointer; the urgent one wins whenever any
  // urgent port is eligible, otherwise every eligible port competes.
  blit_rrpick #(.NPORTS(NPORTS), .IW(IW)) u_pick_urgent (
    .mask  (urgent_elig),
    .start (pick_start),
    .grant (urg_grant),
    .index (urg_index),
    .any   (urg_any)
  );

  blit_rrpick #(.NPORTS(NPORTS), .IW(IW)) u_pick_all (
    .mask  (eligible),
    .start (pick_start),
    .grant (all_grant),
    .index (all_index),
    .any   (all_any)
  );

  assign win_grant = urg_any ? urg_grant : all_grant;
  assign win_index = urg_any ? urg_index : all_index;
  assign rr_next   = (win_index == IW'(NPORTS - 1)) ? '0 : win_index + 1'b1;

  // AND-OR mux of the winning port's access fields, driven by the one-hot grant.
  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    assign addr_m[gi]   = win_grant[gi] ? addr[gi*AW +: AW]   : '0;
    assign wdata_m[gi]  = win_grant[gi] ? wdata[gi*DW +: DW]  : '0;
    assign wstrb_m[gi]  = win_grant[gi] ? wstrb[gi*SW +: SW]  : '0;
    assign we_m[gi]     = win_grant[gi] & we[gi];
    assign g_onehot[gi] = (g_reg == IW'(gi));
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_wstrb = '0;
    for (int p = 0; p < NPORTS; p++) begin
      win_addr  = win_addr  | addr_m[p];
      win_wdata = win_wdata | wdata_m[p];
      win_wstrb = win_wstrb | wstrb_m[p];
    end
  end

  assign win_we = |we_m;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (all_any) state_next = ST_BUSY;
      ST_BUSY: if (ram_ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: decoded actions.  ram_ack outside BUSY never reaches 'finish'.
  always_comb begin
    load_win = 1'b0;
    finish   = 1'b0;
    case (state_reg)
      ST_IDLE: load_win = all_any;
      ST_BUSY: finish   = ram_ack;
      default: begin
        load_win = 1'b0;
        finish   = 1'b0;
      end
    endcase
  end

  // Registered RAM bus, grant bookkeeping and requester responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_req    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wstrb  <= '0;
      ram_we     <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      g_reg      <= '0;
      rr_ptr_reg <= '0;
    end else begin
      ack <= '0;
      if (load_win) begin
        ram_req    <= 1'b1;
        ram_addr   <= win_addr;
        ram_wdata  <= win_wdata;
        ram_wstrb  <= win_wstrb;
        ram_we     <= win_we;
        g_reg      <= win_index;
        rr_ptr_reg <= rr_next;
      end
      if (finish) begin
        ram_req <= 1'b0;
        ram_we  <= 1'b0;
        ack     <= g_onehot;
        // Captured on writes too, so rdata always reflects the last access.
        rdata   <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_blit_ramarbn.sv
// Scoreboard bench for blit_ramarbn.  Two instances run side by side: one in
// fixed-priority mode and one in round-robin mode, each with its own random
// requesters, random-latency RAM and reference model.  The driver predicts
// each grant and each ack from the arbitration rules and queues them with the
// cycle they must appear in; the monitor compares whatever the DUT presents.
module tb_blit_ramarbn;

  localparam int NP = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int SW = DW / 8;
  localparam int NI = 2;
  localparam int NSTEP = 1400;

  typedef struct packed {
    logic [31:0]   due;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } gr_exp_t;

  typedef struct packed {
    logic [31:0]   due;
    logic [NP-1:0] ack;
    logic [DW-1:0] rdata;
  } ack_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_s       [NI];
  logic [NP-1:0]     req_s       [NI];
  logic [NP-1:0]     urg_s       [NI];
  logic [NP-1:0]     we_s        [NI];
  logic [NP*AW-1:0]  addr_s      [NI];
  logic [NP*DW-1:0]  wdata_s     [NI];
  logic [NP*SW-1:0]  wstrb_s     [NI];
  logic              ram_ack_s   [NI];
  logic [DW-1:0]     ram_rdata_s [NI];
  logic [NP-1:0]     ack_s       [NI];
  logic [DW-1:0]     rdata_s     [NI];
  logic              ram_req_s   [NI];
  logic [AW-1:0]     ram_addr_s  [NI];
  logic [DW-1:0]     ram_wdata_s [NI];
  logic [SW-1:0]     ram_wstrb_s [NI];
  logic              ram_we_s    [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    blit_ramarbn #(.NPORTS(NP), .AW(AW), .DW(DW), .RR(gi)) dut (
      .clk       (clk),
      .rst       (rst_s[gi]),
      .req       (req_s[gi]),
      .urgent    (urg_s[gi]),
      .addr      (addr_s[gi]),
      .wdata     (wdata_s[gi]),
      .wstrb     (wstrb_s[gi]),
      .we        (we_s[gi]),
      .ack       (ack_s[gi]),
      .rdata     (rdata_s[gi]),
      .ram_req   (ram_req_s[gi]),
      .ram_addr  (ram_addr_s[gi]),
      .ram_wdata (ram_wdata_s[gi]),
      .ram_wstrb (ram_wstrb_s[gi]),
      .ram_we    (ram_we_s[gi]),
      .ram_ack   (ram_ack_s[gi]),
      .ram_rdata (ram_rdata_s[gi])
    );
  end

  gr_exp_t  gq [NI][$];
  ack_exp_t aq [NI][$];

  int cyc;
  bit done;

  // Reference model state, per instance.
  bit            m_busy  [NI];
  int            m_port  [NI];
  logic [NP-1:0] m_ack   [NI];
  int            m_ptr   [NI];
  int            m_cnt   [NI];
  int            m_age   [NI];
  int            rphase  [NI];
  bit            rst_done[NI];

  // Winner by the arbitration rules: urgent-eligible ports first if any,
  // then lowest index (mode 0) or first index at/after ptr, wrapping (mode 1).
  function automatic int pick(input logic [NP-1:0] elig, input logic [NP-1:0] urg,
                              input int mode, input int ptr);
    logic [NP-1:0] cand;
    int p;
    cand = ((elig & urg) != 0) ? (elig & urg) : elig;
    for (int k = 0; k < NP; k++) begin
      p = (mode == 1) ? (ptr + k) % NP : k;
      if (cand[p]) return p;
    end
    return -1;
  endfunction

  task automatic step(input int i, input int rate, input int urate, input bit want_rst);
    logic [NP-1:0] ack_now, elig, oh;
    logic [DW-1:0] rd;
    bit stray;
    int g;
    gr_exp_t ge;
    ack_exp_t ae;
    stray = 1'b0;
    if (rphase[i] == 2) begin
      rphase[i] = 1;
      return;
    end
    if (rphase[i] == 1) begin
      rst_s[i]  = 1'b0;
      rphase[i] = 0;
      stray     = 1'b1;   // late ram_ack of the abandoned access
    end
    ack_now  = m_ack[i];
    m_ack[i] = '0;
    // Requesters: drop after ack, otherwise maybe raise a fresh request.
    for (int p = 0; p < NP; p++) begin
      if (req_s[i][p] && ack_now[p]) begin
        req_s[i][p] = 1'b0;
      end else if (!req_s[i][p] && ($urandom_range(0, 99) < rate)) begin
        req_s[i][p]              = 1'b1;
        addr_s[i][p*AW +: AW]    = AW'($urandom);
        we_s[i][p]               = 1'($urandom_range(0, 1));
        wdata_s[i][p*DW +: DW]   = DW'($urandom);
        wstrb_s[i][p*SW +: SW]   = SW'($urandom);
      end
      urg_s[i][p] = ($urandom_range(0, 99) < urate);
    end
    if (want_rst && m_busy[i] && m_age[i] >= 1 && m_cnt[i] >= 1) begin
      rst_s[i]     = 1'b1;
      ram_ack_s[i] = 1'b0;
      m_busy[i]    = 1'b0;
      m_ptr[i]     = 0;
      rphase[i]    = 2;
      rst_done[i]  = 1'b1;
      return;
    end
    ram_ack_s[i] = 1'b0;
    if (m_busy[i]) begin
      m_age[i]++;
      if (m_cnt[i] == 0) begin
        rd = DW'($urandom);
        ram_ack_s[i]   = 1'b1;
        ram_rdata_s[i] = rd;
        oh = '0;
        oh[m_port[i]] = 1'b1;
        ae.due = 32'(cyc + 1);
        ae.ack = oh;
        ae.rdata = rd;
        aq[i].push_back(ae);
        m_ack[i]  = oh;
        m_busy[i] = 1'b0;
      end else begin
        m_cnt[i]--;
      end
    end else begin
      if (stray || ($urandom_range(0, 99) < 5)) begin
        ram_ack_s[i]   = 1'b1;
        ram_rdata_s[i] = DW'($urandom);
      end
      elig = req_s[i] & ~ack_now;
      if (elig != 0) begin
        g = pick(elig, urg_s[i], i, m_ptr[i]);
        ge.due   = 32'(cyc + 1);
        ge.addr  = addr_s[i][g*AW +: AW];
        ge.we    = we_s[i][g];
        ge.wdata = wdata_s[i][g*DW +: DW];
        ge.wstrb = wstrb_s[i][g*SW +: SW];
        gq[i].push_back(ge);
        m_busy[i] = 1'b1;
        m_port[i] = g;
        m_age[i]  = 0;
        m_cnt[i]  = $urandom_range(0, 4);
        m_ptr[i]  = (g + 1) % NP;
      end
    end
  endtask

  // Driver
  initial begin
    int rate, urate;
    cyc  = 0;
    done = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rst_s[i] = 1'b1;
      req_s[i] = '0; urg_s[i] = '0; we_s[i] = '0;
      addr_s[i] = '0; wdata_s[i] = '0; wstrb_s[i] = '0;
      ram_ack_s[i] = 1'b0; ram_rdata_s[i] = '0;
      m_busy[i] = 1'b0; m_port[i] = 0; m_ack[i] = '0; m_ptr[i] = 0;
      m_cnt[i] = 0; m_age[i] = 0; rphase[i] = 0; rst_done[i] = 1'b0;
    end
    for (int s = 0; s < NSTEP; s++) begin
      @(negedge clk);
      cyc++;
      if (s < 3) continue;
      if (s < 300)       begin rate = 100; urate = 0;  end
      else if (s < 500)  begin rate = 100; urate = 15; end
      else if (s < 1300) begin rate = 35;  urate = 20; end
      else               begin rate = 0;   urate = 0;  end
      for (int i = 0; i < NI; i++) begin
        if (s == 3) rst_s[i] = 1'b0;
        step(i, rate, urate, (s >= 700 && s < 1000 && !rst_done[i]));
      end
    end
    done = 1'b1;
  end

  // Monitor / scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  bit prev_req [NI];

  task automatic chk(input bit ok, input string nm, input int i,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h want %h", nm, i, cyc, act, exp);
    end
  endtask

  initial begin
    gr_exp_t ge;
    ack_exp_t ae;
    logic [36:0] act_f, exp_f, hold_f [NI];
    bit rise;
    for (int i = 0; i < NI; i++) begin
      prev_req[i] = 1'b0;
      hold_f[i]   = '0;
    end
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        act_f = {ram_addr_s[i], ram_we_s[i], ram_wdata_s[i], ram_wstrb_s[i]};
        if (rst_s[i]) begin
          chk({ram_req_s[i], act_f, ack_s[i], rdata_s[i]} == '0, "reset_vals", i,
              64'({ram_req_s[i], act_f, ack_s[i], rdata_s[i]}), 64'd0);
          gq[i].delete();
          aq[i].delete();
          prev_req[i] = 1'b0;
          continue;
        end
        rise = ram_req_s[i] && !prev_req[i];
        if (gq[i].size() > 0 && gq[i][0].due == 32'(cyc)) begin
          ge = gq[i].pop_front();
          exp_f = {ge.addr, ge.we, ge.wdata, ge.wstrb};
          hold_f[i] = exp_f;
          chk(rise && act_f == exp_f, "grant", i, {26'd0, rise, act_f}, {26'd0, 1'b1, exp_f});
        end else if (rise) begin
          chk(1'b0, "grant_unexpected", i, 64'(act_f), 64'd0);
        end else if (ram_req_s[i]) begin
          chk(act_f == hold_f[i], "ram_hold", i, 64'(act_f), 64'(hold_f[i]));
        end else begin
          chk(ram_we_s[i] == 1'b0, "ram_we_idle", i, 64'(ram_we_s[i]), 64'd0);
        end
        if (aq[i].size() > 0 && aq[i][0].due == 32'(cyc)) begin
          ae = aq[i].pop_front();
          chk({ack_s[i], rdata_s[i]} == {ae.ack, ae.rdata}, "ack", i,
              64'({ack_s[i], rdata_s[i]}), 64'({ae.ack, ae.rdata}));
          $display("dut%0d cycle %0d ack %b rdata %h", i, cyc, ack_s[i], rdata_s[i]);
        end else begin
          chk(ack_s[i] == '0, "ack_spurious", i, 64'(ack_s[i]), 64'd0);
        end
        prev_req[i] = ram_req_s[i];
      end
      if (done) begin
        for (int i = 0; i < NI; i++) begin
          chk(gq[i].size() == 0 && aq[i].size() == 0 && !ram_req_s[i], "drain", i,
              64'(gq[i].size() + aq[i].size()), 64'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

endmodule
